// File: rtl/hidden_layer_mac_if.sv
// Bus bundle between the hidden-layer MAC, its input/weight memories, the bias
// store and the output layer.
interface hidden_layer_mac_if #(
   parameter int unsigned N_IN  = 784,
   parameter int unsigned N_HID = 30,
   parameter int unsigned DW    = 8
);
   localparam int unsigned XAW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned WAW = (N_IN * N_HID > 1) ? $clog2(N_IN * N_HID) : 1;
   localparam int unsigned IW  = (N_HID > 1) ? $clog2(N_HID) : 1;

   logic                  start;
   logic [N_HID*DW-1:0]   bias_flat;
   logic [XAW-1:0]        x_addr;
   logic [DW-1:0]         x_data;
   logic [WAW-1:0]        w_addr;
   logic [DW-1:0]         w_data;
   logic                  busy;
   logic                  out_valid;
   logic [IW-1:0]         out_idx;
   logic [DW-1:0]         out_data;
   logic                  done;

   modport master (
      output start, bias_flat, x_data, w_data,
      input  x_addr, w_addr, busy, out_valid, out_idx, out_data, done
   );

   modport slave (
      input  start, bias_flat, x_data, w_data,
      output x_addr, w_addr, busy, out_valid, out_idx, out_data, done
   );
endinterface

// File: rtl/hidden_layer_mac.sv
// Sequential hidden-layer neuron engine: one shared multiplier, per-neuron
// dot product, shift, bias add, ReLU and saturation to an 8-bit activation.
module hidden_layer_mac #(
   parameter int unsigned N_IN  = 784,
   parameter int unsigned N_HID = 30,
   parameter int unsigned DW    = 8,
   parameter int unsigned ACC_W = 24,
   parameter int unsigned SHIFT = 7
) (
   input  logic             clk,
   input  logic             rst,
   hidden_layer_mac_if.slave bus
);
   localparam int unsigned XAW  = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned WAW  = (N_IN * N_HID > 1) ? $clog2(N_IN * N_HID) : 1;
   localparam int unsigned IW   = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int unsigned PW   = 2 * DW;
   localparam int unsigned RW   = ACC_W + 1;
   localparam int unsigned MAXV = (2 ** (DW - 1)) - 1;

   typedef enum logic [2:0] {
      IDLE,
      MAC,
      DRAIN,
      EMIT,
      DONE
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    busy_nxt;
   logic                    valid_nxt;
   logic                    done_nxt;
   logic [IW-1:0]           n_idx;
   logic signed [ACC_W-1:0] acc;

   logic signed [DW-1:0]    xs_c;
   logic signed [DW-1:0]    ws_c;
   logic signed [DW-1:0]    bias_c;
   logic signed [PW-1:0]    prod_c;
   logic signed [ACC_W-1:0] acc_sum_c;
   logic signed [RW-1:0]    r_c;
   logic [DW-1:0]           sat_c;
   logic                    last_i_c;
   logic                    last_n_c;

   assign last_i_c = (bus.x_addr == XAW'(N_IN - 1));
   assign last_n_c = (n_idx == IW'(N_HID - 1));

   // Next state plus the values the registered status outputs take on the coming edge
   always_comb begin
      state_nxt = state;
      busy_nxt  = 1'b0;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE:    if (bus.start) state_nxt = MAC;
         MAC:     if (last_i_c) state_nxt = DRAIN;
         DRAIN:   state_nxt = EMIT;
         EMIT:    state_nxt = last_n_c ? DONE : MAC;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      busy_nxt  = (state_nxt == MAC) || (state_nxt == DRAIN) || (state_nxt == EMIT);
      valid_nxt = (state_nxt == EMIT);
      done_nxt  = (state_nxt == DONE);
   end

   // Datapath: product of the memory outputs, running sum, scaled+biased result
   always_comb begin
      xs_c      = bus.x_data;
      ws_c      = bus.w_data;
      bias_c    = bus.bias_flat[n_idx * DW +: DW];
      prod_c    = PW'(xs_c) * PW'(ws_c);
      acc_sum_c = acc + ACC_W'(prod_c);
      r_c       = RW'(acc_sum_c >>> SHIFT) + RW'(bias_c);
      if (r_c < 0) begin
         sat_c = '0;
      end else if (r_c > $signed(RW'(MAXV))) begin
         sat_c = DW'(MAXV);
      end else begin
         sat_c = r_c[DW-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         n_idx         <= '0;
         acc           <= '0;
         bus.x_addr    <= '0;
         bus.w_addr    <= '0;
         bus.busy      <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.out_idx   <= '0;
         bus.out_data  <= '0;
         bus.done      <= 1'b0;
      end else begin
         state         <= state_nxt;
         bus.busy      <= busy_nxt;
         bus.out_valid <= valid_nxt;
         bus.done      <= done_nxt;

         // Addresses advance only while issuing; weight address runs on across neurons
         if (state_nxt == MAC) begin
            if (state == MAC) begin
               bus.x_addr <= bus.x_addr + XAW'(1);
               bus.w_addr <= bus.w_addr + WAW'(1);
            end else begin
               bus.x_addr <= '0;
               bus.w_addr <= (state == IDLE) ? '0 : bus.w_addr + WAW'(1);
            end
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  n_idx <= '0;
                  acc   <= '0;
               end
            end
            MAC: begin
               // Read data lags the address by one cycle, so skip the first MAC cycle
               if (bus.x_addr != '0) acc <= acc_sum_c;
            end
            DRAIN: begin
               acc          <= acc_sum_c;
               bus.out_idx  <= n_idx;
               bus.out_data <= sat_c;
            end
            EMIT: begin
               acc   <= '0;
               n_idx <= n_idx + IW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_hidden_layer_mac.sv
// Randomised and directed bench for hidden_layer_mac against a dot-product
// reference model; three instances cover small, shifted and full-size configs.
module tb_hidden_layer_mac;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [7:0] xm   [3][1024];
   logic [7:0] wm   [3][32768];
   logic [7:0] bmem [3][30];
   int         expv [3][30];
   int         vcnt [3];
   int         dcnt [3];

   hidden_layer_mac_if #(.N_IN(4), .N_HID(3), .DW(8)) ifa ();
   hidden_layer_mac_if #(.N_IN(4), .N_HID(3), .DW(8)) ifb ();
   hidden_layer_mac_if #(.N_IN(784), .N_HID(30), .DW(8)) ifc ();

   hidden_layer_mac #(.N_IN(4), .N_HID(3), .DW(8), .ACC_W(24), .SHIFT(0)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa));
   hidden_layer_mac #(.N_IN(4), .N_HID(3), .DW(8), .ACC_W(24), .SHIFT(7)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb));
   hidden_layer_mac #(.N_IN(784), .N_HID(30), .DW(8), .ACC_W(24), .SHIFT(7)) dut_c (
      .clk(clk), .rst(rst), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read input and weight memories
   always @(posedge clk) begin
      ifa.x_data <= xm[0][ifa.x_addr];
      ifa.w_data <= wm[0][ifa.w_addr];
      ifb.x_data <= xm[1][ifb.x_addr];
      ifb.w_data <= wm[1][ifb.w_addr];
      ifc.x_data <= xm[2][ifc.x_addr];
      ifc.w_data <= wm[2][ifc.w_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic int n_in_of(input int w);
      return (w == 2) ? 784 : 4;
   endfunction

   function automatic int n_hid_of(input int w);
      return (w == 2) ? 30 : 3;
   endfunction

   // Reference: signed dot product, arithmetic shift, bias, ReLU, clamp to 127
   function automatic int ref_neuron(input int w, input int n);
      longint acc;
      longint r;
      int     nin;
      int     sh;
      nin = n_in_of(w);
      sh  = (w == 0) ? 0 : 7;
      acc = 0;
      for (int i = 0; i < nin; i++)
         acc += longint'($signed(xm[w][i])) * longint'($signed(wm[w][n * nin + i]));
      r = (acc >>> sh) + longint'($signed(bmem[w][n]));
      if (r < 0) return 0;
      if (r > 127) return 127;
      return int'(r);
   endfunction

   task automatic load_bias(input int w);
      for (int n = 0; n < n_hid_of(w); n++) begin
         case (w)
            0:       ifa.bias_flat[n * 8 +: 8] = bmem[0][n];
            1:       ifb.bias_flat[n * 8 +: 8] = bmem[1][n];
            default: ifc.bias_flat[n * 8 +: 8] = bmem[2][n];
         endcase
      end
   endtask

   task automatic set_start(input int w, input logic v);
      case (w)
         0:       ifa.start = v;
         1:       ifb.start = v;
         default: ifc.start = v;
      endcase
   endtask

   function automatic logic get_done(input int w);
      case (w)
         0:       return ifa.done;
         1:       return ifb.done;
         default: return ifc.done;
      endcase
   endfunction

   function automatic logic [63:0] outs(input int w);
      case (w)
         0:       return 64'({ifa.busy, ifa.out_valid, ifa.out_idx, ifa.out_data, ifa.done, ifa.x_addr, ifa.w_addr});
         1:       return 64'({ifb.busy, ifb.out_valid, ifb.out_idx, ifb.out_data, ifb.done, ifb.x_addr, ifb.w_addr});
         default: return 64'({ifc.busy, ifc.out_valid, ifc.out_idx, ifc.out_data, ifc.done, ifc.x_addr, ifc.w_addr});
      endcase
   endfunction

   task automatic mon(input int w, input string nm, input logic v, input logic [7:0] idx,
                      input logic [7:0] d, input logic dn, input logic bz);
      if (v === 1'b1) begin
         check($sformatf("%s_busy_with_valid", nm), 64'(bz), 64'd1);
         if (vcnt[w] < n_hid_of(w)) begin
            check($sformatf("%s_idx%0d", nm, vcnt[w]), 64'(idx), 64'(vcnt[w]));
            check($sformatf("%s_data%0d", nm, vcnt[w]), 64'(d), 64'(expv[w][vcnt[w]]));
         end
         vcnt[w]++;
      end
      if (dn === 1'b1) begin
         check($sformatf("%s_busy_low_at_done", nm), 64'(bz), 64'd0);
         dcnt[w]++;
      end
   endtask

   always @(negedge clk) begin
      mon(0, "a", ifa.out_valid, 8'(ifa.out_idx), ifa.out_data, ifa.done, ifa.busy);
      mon(1, "b", ifb.out_valid, 8'(ifb.out_idx), ifb.out_data, ifb.done, ifb.busy);
      mon(2, "c", ifc.out_valid, 8'(ifc.out_idx), ifc.out_data, ifc.done, ifc.busy);
   end

   // One full pass: start pulse, bounded wait for done, then pulse counts
   task automatic run_pass(input int w, input string tag);
      int cyc;
      int exp_cyc;
      exp_cyc = n_hid_of(w) * (n_in_of(w) + 2) + 1;
      vcnt[w] = 0;
      dcnt[w] = 0;
      @(negedge clk);
      set_start(w, 1'b1);
      @(negedge clk);
      set_start(w, 1'b0);
      cyc = 1;
      while (get_done(w) !== 1'b1 && cyc < exp_cyc + 50) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
      @(negedge clk);
      check({tag, "_valid_count"}, 64'(vcnt[w]), 64'(n_hid_of(w)));
      check({tag, "_done_count"}, 64'(dcnt[w]), 64'd1);
   endtask

   task automatic fill_const(input int w, input logic [7:0] xv, input logic [7:0] wv);
      for (int i = 0; i < n_in_of(w); i++) xm[w][i] = xv;
      for (int j = 0; j < n_in_of(w) * n_hid_of(w); j++) wm[w][j] = wv;
   endtask

   initial begin
      int cyc;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      for (int w = 0; w < 3; w++) begin
         vcnt[w] = 0;
         dcnt[w] = 0;
         for (int i = 0; i < 1024; i++) xm[w][i] = '0;
         for (int j = 0; j < 32768; j++) wm[w][j] = '0;
         for (int n = 0; n < 30; n++) begin
            bmem[w][n] = '0;
            expv[w][n] = 0;
         end
         set_start(w, 1'b0);
         load_bias(w);
      end
      repeat (3) @(negedge clk);
      check("reset_outs_a", outs(0), 64'd0);
      check("reset_outs_c", outs(2), 64'd0);
      rst = 1'b0;

      // Unit data, zero bias
      fill_const(0, 8'd1, 8'd1);
      check("model_pin_unit", 64'(ref_neuron(0, 0)), 64'd4);
      for (int n = 0; n < 3; n++) expv[0][n] = 4;
      run_pass(0, "t1");

      // Bias -1, -128 (ReLU), +127 (saturate)
      bmem[0][0] = 8'hFF;
      bmem[0][1] = 8'h80;
      bmem[0][2] = 8'h7F;
      load_bias(0);
      check("model_pin_relu", 64'(ref_neuron(0, 1)), 64'd0);
      expv[0][0] = 3;
      expv[0][1] = 0;
      expv[0][2] = 127;
      run_pass(0, "t2");

      // Large products with shift 7
      fill_const(1, 8'd127, 8'd127);
      check("model_pin_sat", 64'(ref_neuron(1, 0)), 64'd127);
      for (int n = 0; n < 3; n++) expv[1][n] = 127;
      run_pass(1, "t3a");
      fill_const(1, 8'h80, 8'd127);
      for (int n = 0; n < 3; n++) expv[1][n] = 0;
      run_pass(1, "t3b");

      // Held start, mid-pass start and a start during DONE all give a single pass
      for (int n = 0; n < 3; n++) bmem[0][n] = '0;
      load_bias(0);
      for (int n = 0; n < 3; n++) expv[0][n] = 4;
      vcnt[0] = 0;
      dcnt[0] = 0;
      @(negedge clk);
      ifa.start = 1'b1;
      @(negedge clk);
      cyc = 1;
      while (ifa.done !== 1'b1 && cyc < 100) begin
         ifa.start = (cyc < 3) || (cyc == 9);
         @(negedge clk);
         cyc++;
      end
      check("t4_done_cycle", 64'(cyc), 64'd19);
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      repeat (30) @(negedge clk);
      check("t4_valid_count", 64'(vcnt[0]), 64'd3);
      check("t4_done_count", 64'(dcnt[0]), 64'd1);

      // Reset during neuron 1 accumulation
      vcnt[0] = 0;
      dcnt[0] = 0;
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      cyc = 0;
      while (ifa.out_valid !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("t5_first_valid_seen", 64'(ifa.out_valid), 64'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_outs_zero_on_reset", outs(0), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("t5_no_done_after_abort", 64'(dcnt[0]), 64'd0);
      check("t5_valid_before_abort", 64'(vcnt[0]), 64'd1);
      run_pass(0, "t5_restart");

      // Random patterns on the small instance
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 4; i++) xm[0][i] = 8'($urandom);
         for (int j = 0; j < 12; j++) wm[0][j] = 8'($urandom);
         for (int n = 0; n < 3; n++) bmem[0][n] = 8'($urandom);
         load_bias(0);
         for (int n = 0; n < 3; n++) expv[0][n] = ref_neuron(0, n);
         run_pass(0, $sformatf("t7_rand%0d", k));
      end

      // Full-size layer with random data
      for (int i = 0; i < 784; i++) xm[2][i] = 8'($urandom);
      for (int j = 0; j < 784 * 30; j++) wm[2][j] = 8'($urandom);
      for (int n = 0; n < 30; n++) bmem[2][n] = 8'($urandom);
      load_bias(2);
      for (int n = 0; n < 30; n++) expv[2][n] = ref_neuron(2, n);
      run_pass(2, "t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
